// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the bidirectional uio[7:0] pad bus: one grant at a time,
// bounded hold time and a forced output-disable gap between consecutive owners.
module uio_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8,
  parameter int TURN_CYC = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     dir,
  input  logic [8*NREQ-1:0]   wdata,
  input  logic [7:0]          uio_in,
  output logic [NREQ-1:0]     gnt,
  output logic [7:0]          uio_out,
  output logic [7:0]          uio_oe,
  output logic [7:0]          rdata,
  output logic                rvalid,
  output logic                busy
);

  localparam int OW = $clog2(NREQ);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic            own_dir_q, own_dir_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [7:0]      hold_cnt_q, hold_cnt_d;
  logic [3:0]      turn_cnt_q, turn_cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic              pick_found;
  logic [OW:0]       pick_sum;
  logic [OW-1:0]     pick_idx;
  logic [OW-1:0]     owner_next;
  logic [7:0]        wsel;
  logic              drive_bus;

  // Rotate requests so bit 0 is the current priority pointer, then take the
  // first set bit and map it back to an absolute requester index.
  always_comb begin
    req_dbl    = {req, req};
    req_rot    = req_dbl[ptr_q +: NREQ];
    pick_found = 1'b0;
    pick_sum   = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!pick_found && req_rot[j]) begin
        pick_found = 1'b1;
        pick_sum   = {1'b0, ptr_q} + (OW+1)'(j);
      end
    end
    if (pick_sum >= (OW+1)'(NREQ)) begin
      pick_sum = pick_sum - (OW+1)'(NREQ);
    end
    pick_idx = pick_sum[OW-1:0];
  end

  always_comb begin
    if (owner_q == OW'(NREQ-1)) begin
      owner_next = '0;
    end else begin
      owner_next = owner_q + 1'b1;
    end
  end

  always_comb begin
    wsel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == OW'(i)) begin
        wsel = wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    own_dir_d  = own_dir_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    gnt_d      = gnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ena && pick_found) begin
          state_d    = ST_GRANT;
          owner_d    = pick_idx;
          own_dir_d  = dir[pick_idx];
          hold_cnt_d = 8'd1;
          gnt_d      = '0;
          gnt_d[pick_idx] = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!req[owner_q] || hold_cnt_q == 8'(MAX_HOLD)) begin
          state_d    = ST_TURN;
          gnt_d      = '0;
          turn_cnt_d = 4'd1;
          ptr_d      = owner_next;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      ST_TURN: begin
        if (turn_cnt_q == 4'(TURN_CYC)) begin
          state_d = ST_IDLE;
        end else begin
          turn_cnt_d = turn_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Read owners capture the pad every GRANT cycle; rvalid trails by one cycle.
  always_comb begin
    rvalid_d = (state_q == ST_GRANT) && !own_dir_q;
    rdata_d  = rvalid_d ? uio_in : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      own_dir_q  <= 1'b0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
      gnt_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      own_dir_q  <= own_dir_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      gnt_q      <= gnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign drive_bus = (state_q == ST_GRANT) && own_dir_q;
  assign gnt       = gnt_q;
  assign uio_oe    = drive_bus ? '1 : '0;
  assign uio_out   = drive_bus ? wsel : '0;
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
